clip_memory_arbiter: RTL and testbench
======================================

# clip_memory_arbiter

Shares the two single-port clip memory banks between the record write stream and the playback read stream. With it, recording one clip while playing the other, or the same clip, is possible. The block sits between the top-level controller and the memory banks and owns one address pointer per stream. It grants one memory access at a time using a request/acknowledge handshake with alternating (round-robin) priority.

## Interface
Parameters:
- ADDR_WIDTH, 18, memory address width
- DATA_WIDTH, 16, sample word width
- CLIP_LAST, 2**ADDR_WIDTH-1, last valid word address of a clip

Ports:
- clock_i  in  1  100 MHz clock
- reset_i  in  1  reset; asynchronous, active-low
- rec_start_i  in  1  pulse: clear record pointer and record full flag, latch rec_clip_i
- rec_clip_i  in  1  record bank select (0 = bank 0, 1 = bank 1)
- rec_req_i  in  1  write request; held high until rec_ack_o
- rec_data_i  in  DATA_WIDTH  write word; must be stable while rec_req_i is high
- rec_ack_o  out  1  one-cycle pulse: write issued
- rec_full_o  out  1  last clip word written; further writes refused
- play_start_i  in  1  pulse: clear play pointer and play end flag, latch play_clip_i
- play_clip_i  in  1  play bank select
- play_req_i  in  1  read request; held high until play_ack_o
- play_ack_o  out  1  one-cycle pulse: read issued
- play_data_o  out  DATA_WIDTH  read word
- play_valid_o  out  1  one-cycle pulse: play_data_o valid
- play_end_o  out  1  last clip word read
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_data_o  out  DATA_WIDTH  memory write data
- mem_data_i  in  DATA_WIDTH  memory read data; valid the cycle after the enable
- mem_rw_o  out  1  1 = write, 0 = read
- mem_0_enable_o  out  1  bank 0 enable
- mem_1_enable_o  out  1  bank 1 enable

## Operation
- FSM states:
  - IDLE: no bank enabled.
  - WRITE: one cycle; the selected bank is enabled, mem_rw_o=1, mem_addr_o=record pointer, mem_data_o=captured rec_data_i, rec_ack_o=1.
  - READ: one cycle; the selected bank is enabled, mem_rw_o=0, mem_addr_o=play pointer, play_ack_o=1.
  - READ_WAIT: one cycle; mem_data_i is captured into play_data_o at the end of the cycle.
- Transitions:
  - IDLE samples requests. An eligible record request (rec_req_i=1, rec_full_o=0) goes to WRITE. An eligible play request (play_req_i=1, play_end_o=0) goes to READ.
  - WRITE goes to IDLE.
  - READ goes to READ_WAIT.
  - READ_WAIT goes to IDLE.
- Tie in IDLE: grant the stream not granted last. A last_grant register resets to "play", so record wins the first tie.
- A requester whose full/end flag is set is ignored and never acknowledged.
- Pointers: ADDR_WIDTH bits.
  - The pointer increments at the end of each WRITE or READ.
  - An access at CLIP_LAST sets rec_full_o or play_end_o and holds the pointer at CLIP_LAST (no wrap).
- A start pulse clears that stream's pointer and flag and latches its clip select.
  - A start pulse in the same cycle as an increment wins: pointer=0, flag=0.
  - An access already in flight completes to the old clip and address.
- Record and play may target the same bank and address. Accesses are serialized; no hazard detection.
- All enables are mutually exclusive. Only the latched clip select chooses the enabled bank.

## Timing
- Reset (async assert, sync deassert), all outputs 0:
  - rec_ack_o=0, rec_full_o=0, play_ack_o=0, play_valid_o=0, play_end_o=0, play_data_o=0
  - mem_addr_o=0, mem_data_o=0, mem_rw_o=0, mem_0_enable_o=0, mem_1_enable_o=0
  - Pointers=0; latched clip selects=0; state=IDLE.
- All outputs are registered.
- Write: request seen in IDLE at cycle N; WRITE and rec_ack_o at N+1; earliest next grant N+2. Throughput is one write per 2 cycles.
- Read: request in IDLE at N; READ and play_ack_o at N+1; READ_WAIT at N+2; play_valid_o with data at N+3; earliest next grant N+3.
- A requester drops req the cycle after seeing ack. A req still high in IDLE after the ack is a new request.
- Reset mid-access aborts it: no ack and no valid pulse are produced afterwards.

## Configuration
- ARB_RECORD_PRIORITY_EN defined: fixed priority. An eligible record request always wins a tie. last_grant is unused.
- Not defined: round-robin alternation as above.

## Test plan
- Reset then rec_start_i with rec_clip_i=1, then 3 writes of 0x0011, 0x0022, 0x0033:
  - mem_1_enable_o pulses at addresses 0, 1, 2 with mem_rw_o=1; mem_0_enable_o stays 0.
  - rec_ack_o pulses 2 cycles apart.
- play_start_i with clip 1, then 3 reads; memory model returns the stored words:
  - play_valid_o at request+3 with 0x0011, 0x0022, 0x0033.
- rec_req_i and play_req_i held continuously:
  - Grants alternate record, play, record, …, record first after reset.
  - With ARB_RECORD_PRIORITY_EN defined, play is never granted.
- CLIP_LAST=3, 5 write requests:
  - 4 acks; rec_full_o=1 after the 4th; the 5th is never acked; mem_addr_o never exceeds 3.
  - rec_start_i clears rec_full_o and the next write goes to address 0.
- rec_start_i coincident with a WRITE at address 5 → next write at address 0.
- reset_i low during READ → no play_valid_o; all outputs 0 immediately.

Source files
------------

// File: rtl/clip_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : clip_memory_arbiter
//  Purpose  : Shares two single-port clip memory banks between a record write
//             stream and a playback read stream, one access at a time.
//             Build option: ARB_RECORD_PRIORITY_EN (record always wins ties).
//  Revision : 1.0
// ============================================================================
module clip_memory_arbiter #(
    parameter int                    ADDR_WIDTH = 18,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] CLIP_LAST  = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  rec_start_i,
    input  logic                  rec_clip_i,
    input  logic                  rec_req_i,
    input  logic [DATA_WIDTH-1:0] rec_data_i,
    output logic                  rec_ack_o,
    output logic                  rec_full_o,
    input  logic                  play_start_i,
    input  logic                  play_clip_i,
    input  logic                  play_req_i,
    output logic                  play_ack_o,
    output logic [DATA_WIDTH-1:0] play_data_o,
    output logic                  play_valid_o,
    output logic                  play_end_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  mem_rw_o,
    output logic                  mem_0_enable_o,
    output logic                  mem_1_enable_o
);

    localparam logic [ADDR_WIDTH-1:0] c_ptr_zero = '0;
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ      = 2'd2,
        ST_READ_WAIT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [1:0]            r_reset_sync;
    logic                  w_reset_n;

    logic [ADDR_WIDTH-1:0] r_rec_ptr;
    logic [ADDR_WIDTH-1:0] r_play_ptr;
    logic                  r_rec_clip;
    logic                  r_play_clip;
    logic                  r_rec_full;
    logic                  r_play_end;

    logic                  r_rec_ack;
    logic                  r_play_ack;
    logic                  r_play_valid;
    logic [DATA_WIDTH-1:0] r_play_data;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  r_mem_rw;
    logic                  r_mem_0_en;
    logic                  r_mem_1_en;

    logic                  w_rec_eligible;
    logic                  w_play_eligible;
    logic                  w_grant_rec;
    logic                  w_grant_play;
    logic                  w_issue_write;
    logic                  w_issue_read;

    // Reset asserts immediately but releases on a clock edge to avoid
    // recovery/removal problems in the downstream flops.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_reset_sync <= 2'b00;
        end else begin
            r_reset_sync <= {r_reset_sync[0], 1'b1};
        end
    end

    assign w_reset_n = r_reset_sync[1];

    assign w_rec_eligible  = rec_req_i  && !r_rec_full;
    assign w_play_eligible = play_req_i && !r_play_end;

`ifdef ARB_RECORD_PRIORITY_EN
    assign w_grant_rec = w_rec_eligible;
`else
    logic r_last_grant_play;

    // On a tie, serve whichever stream was not served last.
    assign w_grant_rec = w_rec_eligible && (!w_play_eligible || r_last_grant_play);

    always_ff @(posedge clock_i or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_last_grant_play <= 1'b1;
        end else if (w_issue_write) begin
            r_last_grant_play <= 1'b0;
        end else if (w_issue_read) begin
            r_last_grant_play <= 1'b1;
        end
    end
`endif

    assign w_grant_play = w_play_eligible && !w_grant_rec;

    always_ff @(posedge clock_i or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_issue_write = 1'b0;
        w_issue_read  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_rec) begin
                    w_next_state  = ST_WRITE;
                    w_issue_write = 1'b1;
                end else if (w_grant_play) begin
                    w_next_state  = ST_READ;
                    w_issue_read  = 1'b1;
                end
            end
            ST_WRITE:     w_next_state = ST_IDLE;
            ST_READ:      w_next_state = ST_READ_WAIT;
            ST_READ_WAIT: w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Memory-side outputs are loaded on the grant edge so the access uses the
    // pointer and clip select that were current when it was granted.
    always_ff @(posedge clock_i or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_rec_ack    <= 1'b0;
            r_play_ack   <= 1'b0;
            r_play_valid <= 1'b0;
            r_play_data  <= '0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_rw     <= 1'b0;
            r_mem_0_en   <= 1'b0;
            r_mem_1_en   <= 1'b0;
        end else begin
            r_rec_ack    <= 1'b0;
            r_play_ack   <= 1'b0;
            r_play_valid <= 1'b0;
            r_mem_0_en   <= 1'b0;
            r_mem_1_en   <= 1'b0;
            if (w_issue_write) begin
                r_mem_addr <= r_rec_ptr;
                r_mem_data <= rec_data_i;
                r_mem_rw   <= 1'b1;
                r_mem_0_en <= !r_rec_clip;
                r_mem_1_en <= r_rec_clip;
                r_rec_ack  <= 1'b1;
            end else if (w_issue_read) begin
                r_mem_addr <= r_play_ptr;
                r_mem_rw   <= 1'b0;
                r_mem_0_en <= !r_play_clip;
                r_mem_1_en <= r_play_clip;
                r_play_ack <= 1'b1;
            end
            if (r_state == ST_READ_WAIT) begin
                r_play_data  <= mem_data_i;
                r_play_valid <= 1'b1;
            end
        end
    end

    // A start pulse overrides the end-of-access increment.
    always_ff @(posedge clock_i or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_rec_ptr  <= c_ptr_zero;
            r_rec_full <= 1'b0;
            r_rec_clip <= 1'b0;
        end else if (rec_start_i) begin
            r_rec_ptr  <= c_ptr_zero;
            r_rec_full <= 1'b0;
            r_rec_clip <= rec_clip_i;
        end else if (r_state == ST_WRITE) begin
            if (r_rec_ptr == CLIP_LAST) begin
                r_rec_full <= 1'b1;
            end else begin
                r_rec_ptr <= r_rec_ptr + c_ptr_one;
            end
        end
    end

    always_ff @(posedge clock_i or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_play_ptr  <= c_ptr_zero;
            r_play_end  <= 1'b0;
            r_play_clip <= 1'b0;
        end else if (play_start_i) begin
            r_play_ptr  <= c_ptr_zero;
            r_play_end  <= 1'b0;
            r_play_clip <= play_clip_i;
        end else if (r_state == ST_READ) begin
            if (r_play_ptr == CLIP_LAST) begin
                r_play_end <= 1'b1;
            end else begin
                r_play_ptr <= r_play_ptr + c_ptr_one;
            end
        end
    end

    assign rec_ack_o      = r_rec_ack;
    assign rec_full_o     = r_rec_full;
    assign play_ack_o     = r_play_ack;
    assign play_data_o    = r_play_data;
    assign play_valid_o   = r_play_valid;
    assign play_end_o     = r_play_end;
    assign mem_addr_o     = r_mem_addr;
    assign mem_data_o     = r_mem_data;
    assign mem_rw_o       = r_mem_rw;
    assign mem_0_enable_o = r_mem_0_en;
    assign mem_1_enable_o = r_mem_1_en;

endmodule
`default_nettype wire

// File: tb/tb_clip_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clip_memory_arbiter
//  Purpose  : Scoreboard bench for clip_memory_arbiter with a two-bank memory
//             model and a small-clip instance for the full-flag boundary.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_clip_memory_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;

    typedef struct packed {
        logic          rw;
        logic          bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } access_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle++;

    int num_checks = 0;
    int num_errors = 0;

    access_t       q_mem[$];
    logic [DW-1:0] q_play[$];

    logic          reset_n;
    logic          rec_start, rec_clip, rec_req, play_start, play_clip, play_req;
    logic [DW-1:0] rec_data;
    logic          rec_ack_o, rec_full_o, play_ack_o, play_valid_o, play_end_o;
    logic [DW-1:0] play_data_o, mem_data_o, mem_rdata;
    logic [AW-1:0] mem_addr_o;
    logic          mem_rw_o, mem_0_enable_o, mem_1_enable_o;

    logic          s_rec_start, s_rec_req, s_rec_ack, s_rec_full;
    logic [DW-1:0] s_rec_data, s_play_data, s_mem_data;
    logic          s_play_ack, s_play_valid, s_play_end, s_mem_rw, s_mem0, s_mem1;
    logic [AW-1:0] s_mem_addr;
    logic          s_zero = 1'b0;
    logic [DW-1:0] s_zero_data = '0;

    clip_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .clock_i(clock), .reset_i(reset_n),
        .rec_start_i(rec_start), .rec_clip_i(rec_clip), .rec_req_i(rec_req),
        .rec_data_i(rec_data), .rec_ack_o(rec_ack_o), .rec_full_o(rec_full_o),
        .play_start_i(play_start), .play_clip_i(play_clip), .play_req_i(play_req),
        .play_ack_o(play_ack_o), .play_data_o(play_data_o), .play_valid_o(play_valid_o),
        .play_end_o(play_end_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_rdata), .mem_rw_o(mem_rw_o),
        .mem_0_enable_o(mem_0_enable_o), .mem_1_enable_o(mem_1_enable_o)
    );

    clip_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLIP_LAST(4'd3)) u_small (
        .clock_i(clock), .reset_i(reset_n),
        .rec_start_i(s_rec_start), .rec_clip_i(s_zero), .rec_req_i(s_rec_req),
        .rec_data_i(s_rec_data), .rec_ack_o(s_rec_ack), .rec_full_o(s_rec_full),
        .play_start_i(s_zero), .play_clip_i(s_zero), .play_req_i(s_zero),
        .play_ack_o(s_play_ack), .play_data_o(s_play_data), .play_valid_o(s_play_valid),
        .play_end_o(s_play_end), .mem_addr_o(s_mem_addr), .mem_data_o(s_mem_data),
        .mem_data_i(s_zero_data), .mem_rw_o(s_mem_rw),
        .mem_0_enable_o(s_mem0), .mem_1_enable_o(s_mem1)
    );

    // Two-bank memory: read data appears the cycle after the enable.
    logic [DW-1:0] bank0 [16];
    logic [DW-1:0] bank1 [16];
    always @(posedge clock) begin
        if (mem_0_enable_o) begin
            if (mem_rw_o) bank0[mem_addr_o] <= mem_data_o;
            else          mem_rdata <= bank0[mem_addr_o];
        end
        if (mem_1_enable_o) begin
            if (mem_rw_o) bank1[mem_addr_o] <= mem_data_o;
            else          mem_rdata <= bank1[mem_addr_o];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic access_t mk(input logic rw, input logic bank, input int addr, input logic [DW-1:0] data);
        mk = '{rw: rw, bank: bank, addr: AW'(addr), data: data};
    endfunction

    // Scoreboard monitor: pops one expectation per observed access / data pulse.
    always @(negedge clock) begin
        access_t act;
        access_t exp;
        if (mem_0_enable_o || mem_1_enable_o) begin
            act = mk(mem_rw_o, mem_1_enable_o, int'(mem_addr_o), mem_rw_o ? mem_data_o : '0);
            if (mem_0_enable_o && mem_1_enable_o) begin
                check("bank_enables_exclusive", 32'd3, 32'd1);
            end else if (q_mem.size() == 0) begin
                check("unexpected_mem_access", 32'(act), 32'hFFFFFFFF);
            end else begin
                exp = q_mem.pop_front();
                check("mem_access", 32'(act), 32'(exp));
            end
        end
        if (play_valid_o) begin
            if (q_play.size() == 0) check("unexpected_play_valid", 32'(play_data_o), 32'hFFFFFFFF);
            else                    check("play_data", 32'(play_data_o), 32'(q_play.pop_front()));
        end
        if (s_mem0 || s_mem1) check("small_addr_bound", 32'(s_mem_addr <= 4'd3), 32'd1);
    end

    task automatic wait_sig(input int which, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clock);
            case (which)
                0:       seen = rec_ack_o;
                1:       seen = play_ack_o;
                2:       seen = play_valid_o;
                default: seen = s_rec_ack;
            endcase
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_flags"}, 32'({rec_ack_o, rec_full_o, play_ack_o, play_valid_o, play_end_o,
                                      mem_rw_o, mem_0_enable_o, mem_1_enable_o}), 32'd0);
        check({name, "_play_data"}, 32'(play_data_o), 32'd0);
        check({name, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
        check({name, "_mem_data"}, 32'(mem_data_o), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic do_write(input int addr, input logic [DW-1:0] data, input bit start_at_ack);
        bit seen;
        q_mem.push_back(mk(1'b1, 1'b0, addr, data));
        rec_data = data;
        rec_req  = 1'b1;
        wait_sig(0, 20, seen);
        check("write_ack_seen", 32'(seen), 32'd1);
        rec_req = 1'b0;
        if (start_at_ack) rec_start = 1'b1;
        @(negedge clock);
        rec_start = 1'b0;
    endtask

    logic [DW-1:0] wdata [3] = '{16'h0011, 16'h0022, 16'h0033};

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        int prev, t0, acks;
        for (int i = 0; i < 16; i++) begin bank0[i] = '0; bank1[i] = '0; end
        mem_rdata = '0;
        {rec_start, rec_clip, rec_req, play_start, play_clip, play_req} = '0;
        rec_data = '0;
        {s_rec_start, s_rec_req} = '0;
        s_rec_data = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // Small clip: four writes accepted, fifth refused, restart clears full.
        s_rec_start = 1'b1; @(negedge clock); s_rec_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_rec_data = DW'(i);
            s_rec_req  = 1'b1;
            wait_sig(3, 10, seen);
            check("small_ack", 32'(seen), 32'd1);
            check("small_write_addr", 32'(s_mem_addr), 32'(i));
            s_rec_req = 1'b0;
            @(negedge clock);
            check("small_full_flag", 32'(s_rec_full), (i == 3) ? 32'd1 : 32'd0);
        end
        s_rec_req = 1'b1;
        wait_sig(3, 10, seen);
        check("small_fifth_refused", 32'(seen), 32'd0);
        s_rec_req = 1'b0;
        s_rec_start = 1'b1; @(negedge clock); s_rec_start = 1'b0;
        check("small_full_cleared", 32'(s_rec_full), 32'd0);
        s_rec_req = 1'b1;
        wait_sig(3, 10, seen);
        check("small_restart_ack", 32'(seen), 32'd1);
        check("small_restart_addr", 32'(s_mem_addr), 32'd0);
        s_rec_req = 1'b0;
        @(negedge clock);

        // Three writes to bank 1 with request held; acks two cycles apart.
        rec_clip = 1'b1; rec_start = 1'b1; @(negedge clock); rec_start = 1'b0;
        rec_data = wdata[0];
        q_mem.push_back(mk(1'b1, 1'b1, 0, wdata[0]));
        rec_req = 1'b1;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_sig(0, 20, seen);
            check("rec_ack_seen", 32'(seen), 32'd1);
            if (k > 0) check("rec_ack_gap", 32'(cycle - prev), 32'd2);
            prev = cycle;
            if (k < 2) begin
                rec_data = wdata[k+1];
                q_mem.push_back(mk(1'b1, 1'b1, k + 1, wdata[k+1]));
            end else begin
                rec_req = 1'b0;
            end
        end
        @(negedge clock);

        // Three reads back from bank 1; data arrives at request + 3.
        play_clip = 1'b1; play_start = 1'b1; @(negedge clock); play_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            q_mem.push_back(mk(1'b0, 1'b1, k, '0));
            q_play.push_back(wdata[k]);
            play_req = 1'b1;
            t0 = cycle;
            wait_sig(1, 20, seen);
            check("play_ack_seen", 32'(seen), 32'd1);
            play_req = 1'b0;
            wait_sig(2, 20, seen);
            check("play_valid_seen", 32'(seen), 32'd1);
            check("play_valid_latency", 32'(cycle - t0), 32'd3);
        end

        // Both requests held from reset: grant order on bank 0.
        do_reset();
        rec_clip = 1'b0; play_clip = 1'b0;
`ifdef ARB_RECORD_PRIORITY_EN
        for (int k = 0; k < 6; k++) q_mem.push_back(mk(1'b1, 1'b0, k, DW'(16'h00A0 + k)));
`else
        for (int k = 0; k < 3; k++) begin
            q_mem.push_back(mk(1'b1, 1'b0, k, DW'(16'h00A0 + k)));
            q_mem.push_back(mk(1'b0, 1'b0, k, '0));
            q_play.push_back(DW'(16'h00A0 + k));
        end
`endif
        rec_data = 16'h00A0;
        rec_req = 1'b1; play_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 60 && acks < 6; i++) begin
            @(negedge clock);
            if (rec_ack_o) begin rec_data = rec_data + 16'd1; acks++; end
            if (play_ack_o) acks++;
        end
        rec_req = 1'b0; play_req = 1'b0;
        check("held_request_grants", 32'(acks), 32'd6);
        repeat (4) @(negedge clock);

        // Restart coinciding with the write at address 5.
        rec_start = 1'b1; @(negedge clock); rec_start = 1'b0;
        for (int k = 0; k < 6; k++) do_write(k, DW'(16'h0050 + k), k == 5);
        do_write(0, 16'h0060, 1'b0);

        // Reset during a read: outputs clear at once and no data follows.
        play_start = 1'b1; @(negedge clock); play_start = 1'b0;
        q_mem.push_back(mk(1'b0, 1'b0, 0, '0));
        play_req = 1'b1;
        wait_sig(1, 20, seen);
        check("abort_read_ack", 32'(seen), 32'd1);
        #2 reset_n = 1'b0;
        play_req = 1'b0;
        #1 check_outputs_zero("abort_reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (8) @(negedge clock);

        check("mem_queue_drained", 32'(q_mem.size()), 32'd0);
        check("play_queue_drained", 32'(q_play.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
`default_nettype wire
